gpio_nibble_rx: RTL and testbench

Receive-side decoder for the 4-bit GPIO nibble bus driven by the table-based GPIO init writer.
- Samples the bus once per 3-phase frame slot.
- Drops pad codes and assembles data nibbles into a record.
- On the end-of-record code, presents the packed record on a valid/ready output to the downstream configuration logic.

---
 rtl/gpio_nibble_rx.sv | 154 +++++++++++++++
 tb/tb_gpio_nibble_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_nibble_rx.sv
// Receive-side decoder for the 4-bit GPIO nibble bus. It samples once per frame slot,
// drops pad codes, packs data nibbles into a record and presents it on END via valid/ready.
module gpio_nibble_rx #(
  parameter int              NIB_W        = 4,
  parameter int              MAX_NIBS     = 8,
  parameter int              PHASES       = 3,
  parameter int              SAMPLE_PHASE = 2,
  parameter logic [NIB_W-1:0] PAD_CODE    = 4'b1111,
  parameter logic [NIB_W-1:0] END_CODE    = 4'b1100,
  localparam int             CW           = $clog2(MAX_NIBS + 1),
  localparam int             RW           = MAX_NIBS * NIB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [NIB_W-1:0] gpio_in,
  input  logic             rec_ready,
  output logic             rec_valid,
  output logic [RW-1:0]    rec_data,
  output logic [CW-1:0]    rec_count,
  output logic             rec_ovf,
  output logic             rec_lost,
  output logic [1:0]       dbg_state_o
);

  localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_e;

  // Output handshake: rec_valid stays high with rec_data/rec_count/rec_ovf stable until an
  // edge where rec_ready is also high; that edge completes the transfer and drops rec_valid.

  state_e           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             samp_v_q, samp_v_d;
  logic [NIB_W-1:0] samp_q, samp_d;
  logic [RW-1:0]    buf_q, buf_d, buf_ins;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [RW-1:0]    data_q, data_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rovf_q, rovf_d;
  logic             lost_q, lost_d;
  logic             is_data, is_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      samp_v_q <= 1'b0;
      samp_q   <= '0;
      buf_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      count_q  <= '0;
      rovf_q   <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      samp_v_q <= samp_v_d;
      samp_q   <= samp_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      count_q  <= count_d;
      rovf_q   <= rovf_d;
      lost_q   <= lost_d;
    end
  end

  // The bus is captured into samp_q on the strobe and decoded one edge later.
  always_comb begin
    phase_d  = phase_q;
    if (ce) phase_d = (phase_q == PW'(PHASES - 1)) ? '0 : phase_q + PW'(1);
    samp_v_d = ce && (phase_q == PW'(SAMPLE_PHASE));
    samp_d   = samp_v_d ? gpio_in : samp_q;
  end

  assign is_data = samp_v_q && (samp_q != PAD_CODE) && (samp_q != END_CODE);
  assign is_end  = samp_v_q && (samp_q == END_CODE);

  always_comb begin
    buf_ins = buf_q;
    for (int k = 0; k < MAX_NIBS; k++) begin
      if (CW'(k) == cnt_q) buf_ins[k*NIB_W +: NIB_W] = samp_q;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    rovf_d  = rovf_q;
    lost_d  = lost_q;
    case (state_q)
      S_IDLE: begin
        if (is_data) begin
          buf_d   = buf_ins;
          cnt_d   = CW'(1);
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (is_data) begin
          if (cnt_q < CW'(MAX_NIBS)) begin
            buf_d = buf_ins;
            cnt_d = cnt_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else if (is_end) begin
          data_d  = buf_q;
          count_d = cnt_q;
          rovf_d  = ovf_q;
          valid_d = 1'b1;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (is_data) lost_d = 1'b1;
        if (rec_ready) begin
          valid_d = 1'b0;
          buf_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rec_valid   = valid_q;
  assign rec_data    = data_q;
  assign rec_count   = count_q;
  assign rec_ovf     = rovf_q;
  assign rec_lost    = lost_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gpio_nibble_rx.sv
// Bench for gpio_nibble_rx: record table, hand-written corner sequences and a random run,
// all checked every cycle against a queue-based model of the record rules.
module tb_gpio_nibble_rx;

  logic        clk = 1'b0;
  logic        rst, ce, rec_ready;
  logic [3:0]  gpio_in;
  logic        rec_valid, rec_ovf, rec_lost;
  logic [31:0] rec_data;
  logic [3:0]  rec_count;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  gpio_nibble_rx dut (
    .clk(clk), .rst(rst), .ce(ce), .gpio_in(gpio_in), .rec_ready(rec_ready),
    .rec_valid(rec_valid), .rec_data(rec_data), .rec_count(rec_count),
    .rec_ovf(rec_ovf), .rec_lost(rec_lost), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [3:0]  m_q[$];
  logic        m_qovf, m_pend, m_ovf, m_lost, m_sv;
  logic [31:0] m_data;
  int          m_cnt, m_en;
  logic [3:0]  m_snib;

  task automatic model_step(input logic r, input logic c, input logic [3:0] g, input logic rdy);
    logic pend0;
    if (r) begin
      m_q.delete(); m_qovf = 0; m_pend = 0; m_ovf = 0; m_lost = 0; m_data = 0; m_cnt = 0;
      m_en = 0; m_sv = 0; m_snib = 0;
      return;
    end
    pend0 = m_pend;
    if (m_sv) begin
      if (m_snib != 4'hF && m_snib != 4'hC) begin
        if (pend0) m_lost = 1;
        else if (m_q.size() < 8) m_q.push_back(m_snib);
        else m_qovf = 1;
      end else if (m_snib == 4'hC && !pend0 && m_q.size() > 0) begin
        m_data = 0;
        foreach (m_q[k]) m_data[4*k +: 4] = m_q[k];
        m_cnt = m_q.size(); m_ovf = m_qovf; m_pend = 1;
        m_q.delete(); m_qovf = 0;
      end
    end
    if (pend0 && rdy) m_pend = 0;
    m_sv = c && (m_en % 3 == 2);
    m_snib = g;
    if (c) m_en++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  int          cyc = 0, pulses = 0, rise_cyc = -1;
  logic        prev_v = 0;
  logic [31:0] cap_data;
  logic [3:0]  cap_cnt;
  logic        cap_ovf;

  task automatic tick(input logic r, input logic c, input logic [3:0] g, input logic rdy);
    rst = r; ce = c; gpio_in = g; rec_ready = rdy;
    @(posedge clk);
    model_step(r, c, g, rdy);
    #1;
    cyc++;
    check("valid", rec_valid, m_pend);
    check("lost", rec_lost, m_lost);
    if (m_pend) begin
      check("data", rec_data, m_data);
      check("count", rec_count, m_cnt);
      check("ovf", rec_ovf, m_ovf);
    end
    if (rec_valid && !prev_v) begin
      pulses++; rise_cyc = cyc;
      cap_data = rec_data; cap_cnt = rec_count; cap_ovf = rec_ovf;
    end
    prev_v = rec_valid;
  endtask

  task automatic send(input logic [3:0] n, input logic rdy);
    repeat (3) tick(1'b0, 1'b1, n, rdy);
  endtask

  typedef struct {
    logic [47:0] seq;
    int          len;
    logic [31:0] exp_data;
    int          exp_cnt;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int end_cyc;
    vecs[0] = '{48'h2222F333FC,  10, 32'h03332222, 7, 1'b0};
    vecs[1] = '{48'h88FFFFFFFC,  10, 32'h00000088, 2, 1'b0};
    vecs[2] = '{48'h123456789AC, 11, 32'h87654321, 8, 1'b1};
    vecs[3] = '{48'hFFC000C,     7,  32'h00000000, 3, 1'b0};
    vecs[4] = '{48'hEDB0C,       5,  32'h00000BDE, 4, 1'b0};
    vecs[5] = '{48'h5C,          2,  32'h00000005, 1, 1'b0};

    tick(1'b1, 1'b0, 4'h0, 1'b0);
    check("rst_valid", rec_valid, 0);
    check("rst_data", rec_data, 0);
    check("rst_count", rec_count, 0);
    check("rst_ovf", rec_ovf, 0);
    check("rst_lost", rec_lost, 0);

    foreach (vecs[i]) begin
      tick(1'b1, 1'b0, 4'h0, 1'b1);
      pulses = 0;
      for (int j = 0; j < vecs[i].len; j++)
        send(vecs[i].seq[4*(vecs[i].len-1-j) +: 4], 1'b1);
      end_cyc = cyc;
      repeat (6) tick(1'b0, 1'b1, 4'hF, 1'b1);
      check($sformatf("v%0d_pulses", i), pulses, 1);
      check($sformatf("v%0d_latency", i), rise_cyc, end_cyc + 1);
      check($sformatf("v%0d_data", i), cap_data, vecs[i].exp_data);
      check($sformatf("v%0d_count", i), cap_cnt, vecs[i].exp_cnt);
      check($sformatf("v%0d_ovf", i), cap_ovf, vecs[i].exp_ovf);
    end

    // Backpressure: second record's data is lost while the first is held.
    tick(1'b1, 1'b0, 4'h0, 1'b0);
    send(4'h7, 1'b0); send(4'hC, 1'b0);
    repeat (2) tick(1'b0, 1'b1, 4'hF, 1'b0);
    check("bp_valid", rec_valid, 1);
    check("bp_data", rec_data, 32'h7);
    check("bp_count", rec_count, 1);
    send(4'h5, 1'b0); send(4'hC, 1'b0);
    tick(1'b0, 1'b1, 4'hF, 1'b0);
    check("bp_hold_valid", rec_valid, 1);
    check("bp_hold_data", rec_data, 32'h7);
    check("bp_lost", rec_lost, 1);
    tick(1'b0, 1'b1, 4'hF, 1'b1);
    check("bp_release", rec_valid, 0);
    check("bp_lost_sticky", rec_lost, 1);

    // ce held low mid-record: no sampling while frozen.
    tick(1'b1, 1'b0, 4'h0, 1'b1);
    pulses = 0;
    send(4'h1, 1'b1); send(4'h2, 1'b1);
    repeat (5) tick(1'b0, 1'b0, 4'h9, 1'b1);
    send(4'h3, 1'b1); send(4'hC, 1'b1);
    repeat (4) tick(1'b0, 1'b1, 4'hF, 1'b1);
    check("ce_pulses", pulses, 1);
    check("ce_data", cap_data, 32'h321);
    check("ce_count", cap_cnt, 3);

    // Reset mid-record discards the partial data.
    send(4'h1, 1'b1); send(4'h2, 1'b1); send(4'h3, 1'b1);
    tick(1'b1, 1'b0, 4'hF, 1'b1);
    pulses = 0;
    send(4'hC, 1'b1);
    repeat (4) tick(1'b0, 1'b1, 4'hF, 1'b1);
    check("mr_pulses", pulses, 0);
    check("mr_valid", rec_valid, 0);
    check("mr_data", rec_data, 0);
    check("mr_count", rec_count, 0);
    check("mr_ovf", rec_ovf, 0);
    check("mr_lost", rec_lost, 0);

    // Random traffic against the model.
    tick(1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [3:0] g;
      r = $urandom_range(0, 9);
      g = (r < 2) ? 4'hF : (r < 4) ? 4'hC : 4'($urandom_range(0, 15));
      tick($urandom_range(0, 599) == 0, $urandom_range(0, 3) != 0, g,
           $urandom_range(0, 2) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
